prog_loader: RTL and testbench
==============================

# prog_loader

Boot-time program loader that sits upstream of the RV64I `Top` core and its instruction/data memories. It accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit words and writes them into memory at consecutive word addresses. It holds the core in reset until the whole image has landed and its checksum matches. It replaces `$readmemh` preloading in system-level benches and on silicon.

## Interface

Parameters:
- `ADDR_W`, default 16: byte-address width of the memory write port. The image address wraps modulo 2^ADDR_W.

Ports:
- `clk`, in, 1: single clock; all state changes on its rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: source presents a byte.
- `in_data`, in, 8: stream byte.
- `in_ready`, out, 1: loader can accept a byte.
- `mem_we`, out, 1: one-cycle word-write strobe to IM/DM.
- `mem_addr`, out, ADDR_W: byte address of the write; always 4-aligned.
- `mem_wdata`, out, 32: write word.
- `core_rst_n`, out, 1: active-low reset to the core; 0 until a successful load.
- `done`, out, 1: load completed with a good checksum. Sticky.
- `err`, out, 1: load aborted. Sticky.

## Operation

- **Accept rule:** a byte is consumed on a rising edge where `in_valid && in_ready`. Bytes presented while `in_ready = 0` are ignored.
- **Frame format:**
  - BASE: 4 bytes, little-endian 32-bit byte address. Only the low ADDR_W bits are used.
  - LEN: 4 bytes, little-endian 32-bit word count.
  - PAYLOAD: 4×LEN bytes, each word least-significant byte first.
  - CSUM: 1 byte, equal to the XOR of all payload bytes. Header bytes are excluded.
- **States:**
  - S_BASE. Counts 4 bytes. After the 4th byte: if BASE[1:0] != 0, go to S_ERR; otherwise go to S_LEN.
  - S_LEN. Counts 4 bytes. After the 4th byte: if LEN == 0, go to S_CSUM; otherwise go to S_DATA.
  - S_DATA. Shifts bytes into a 32-bit word and updates the running XOR. Each 4th byte issues a write. After the last word is accepted, go to S_CSUM.
  - S_CSUM. Accepts one byte. If it equals the running XOR, go to S_DONE; otherwise go to S_ERR.
  - S_DONE and S_ERR are terminal until `rst_n` is asserted.
- **Write address:** word k (0-based) is written at `(BASE + 4k) mod 2^ADDR_W`, using an ADDR_W-bit adder that wraps silently.
- **Word count:** the LEN counter is 32 bits. The loader does not bound-check LEN against memory size.
- **Back-pressure:** `in_ready` is 1 in S_BASE, S_LEN, S_DATA and S_CSUM, and 0 in S_DONE and S_ERR. The memory port never stalls, so back-to-back bytes every cycle are legal.
- **Output gating:**
  - `core_rst_n = 1` only in S_DONE.
  - `err = 1` only in S_ERR.
  - `done = 1` only in S_DONE.
  - No `mem_we` is issued after entering S_ERR.

## Timing

- **Reset values:** while `rst_n = 0`, all of the following are 0: `in_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `core_rst_n`, `done`, `err`. The state is S_BASE with all counters and the XOR cleared.
- **After reset:** `in_ready` rises on the first `clk` edge after `rst_n` deasserts. All outputs are registered.
- **Write latency:** `mem_we`, `mem_addr` and `mem_wdata` are valid in the cycle following the edge that accepted the 4th byte of a word. `mem_we` is high for exactly one cycle per word.
- **Completion latency:** `done` and `core_rst_n` rise 1 cycle after the edge that accepts a matching CSUM byte. The final payload write (the cycle after its 4th byte) therefore always precedes `core_rst_n` release by at least 1 cycle.
- **Misaligned BASE:** `err` rises 1 cycle after the 4th BASE byte is accepted, and `in_ready` falls in that same cycle.
- **Bad checksum:** `err` rises 1 cycle after the CSUM byte is accepted.
- **Reset mid-load:** `rst_n` asserted at any point, including mid-word, clears everything asynchronously. A partially assembled word is never written. A fresh frame is accepted after deassertion.
- **Idle source:** `in_valid` gaps of any length only stall progress. The result is identical to a gap-free stream.

## Test plan

1. **Basic load.** BASE=0x00000000, LEN=2, bytes `13 00 00 00 6F 00 00 00`, CSUM=0x7C.
   Required: `mem_we` at addr 0x0000 with data 0x00000013, then at 0x0004 with 0x0000006F. Then `done=1`, `core_rst_n=1`, `in_ready=0`, `err=0`.
2. **Bad checksum.** Same frame as scenario 1 with CSUM=0x00.
   Required: both writes occur, then `err=1`, `done=0`, `core_rst_n` stays 0, `in_ready=0`. Extra bytes are ignored.
3. **Misaligned base.** BASE=0x00009002.
   Required: `err=1` one cycle after the 4th header byte. No `mem_we` ever. LEN bytes are not accepted.
4. **Zero length and wrap-around.**
   - LEN=0 with CSUM=0x00: `done=1`, zero writes.
   - Separately, with ADDR_W=16, BASE=0xFFFC and LEN=2: writes land at 0xFFFC and then 0x0000.
5. **Random `in_valid` gaps.** Repeat scenario 1 with 0–5 idle cycles between bytes.
   Required: the identical write sequence and final `done`/`core_rst_n`.
6. **Reset mid-payload.** Assert `rst_n` after 2 bytes of word 1.
   Required: all outputs are 0 immediately and no write for word 1 occurs. A subsequent full scenario-1 frame completes normally.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a BASE/LEN/PAYLOAD/CSUM byte stream, writes little-endian
// 32-bit words to memory and releases the core reset once the checksum matches.
module prog_loader #(
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_rst_n,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {SBase, SLen, SData, SCsum, SDone, SErr} state_e;

   state_e              state_q, state_d;
   logic [1:0]          cnt_q, cnt_d;
   logic [23:0]         word_q, word_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         len_q, len_d;
   logic [7:0]          xor_q, xor_d;
   logic                in_ready_q, in_ready_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic        accept;
   logic        last_byte;
   logic [31:0] full;

   assign accept    = in_valid && in_ready_q;
   assign last_byte = (cnt_q == 2'd3);
   // Bytes arrive LSB first, so the newest byte lands on top of the three held ones.
   assign full      = {in_data, word_q};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      addr_d      = addr_q;
      len_d       = len_q;
      xor_d       = xor_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      if (accept) begin
         cnt_d  = cnt_q + 2'd1;
         word_d = full[31:8];
         unique case (state_q)
            SBase: begin
               if (last_byte) begin
                  addr_d  = full[ADDR_W-1:0];
                  state_d = (full[1:0] != 2'd0) ? SErr : SLen;
               end
            end
            SLen: begin
               if (last_byte) begin
                  len_d   = full;
                  state_d = (full == 32'd0) ? SCsum : SData;
               end
            end
            SData: begin
               xor_d = xor_q ^ in_data;
               if (last_byte) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = addr_q;
                  mem_wdata_d = full;
                  addr_d      = addr_q + ADDR_W'(4);
                  len_d       = len_q - 32'd1;
                  if (len_q == 32'd1) begin
                     state_d = SCsum;
                  end
               end
            end
            SCsum: begin
               cnt_d   = 2'd0;
               state_d = (in_data == xor_q) ? SDone : SErr;
            end
            default: ;
         endcase
      end

      in_ready_d = (state_d != SDone) && (state_d != SErr);
      done_d     = (state_d == SDone);
      err_d      = (state_d == SErr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SBase;
         cnt_q       <= 2'd0;
         word_q      <= 24'd0;
         addr_q      <= '0;
         len_q       <= 32'd0;
         xor_q       <= 8'd0;
         in_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         xor_q       <= xor_d;
         in_ready_q  <= in_ready_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign core_rst_n = done_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of frames plus a reset-mid-payload sequence; expected writes
// are queued as bytes are driven and checked against the memory port as they appear.
module tb_prog_loader;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'd0;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          core_rst_n;
   logic          done;
   logic          err;

   prog_loader #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .core_rst_n(core_rst_n),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] base;
      logic [31:0] len;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [7:0]  csum;
      int          gap_max;
      bit          base_only;
      bit          exp_done;
      bit          exp_err;
   } vec_t;

   vec_t          tv[6];
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [AW+31:0] exp_q[$];
   logic [AW+31:0] mon_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Write monitor: every strobe must match the oldest queued expectation.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                     mem_addr, mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(mon_e[AW+31:32]));
            chk("wr_data", mem_wdata, mon_e[31:0]);
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      exp_q.delete();
      #12;
      chk_all_zero("reset");
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("in_ready_after_reset", 32'(in_ready), 32'd1);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gm);
      int gap;
      int i;
      gap = (gm > 0) ? int'($urandom_range(gm, 0)) : 0;
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      i = 0;
      while (!in_ready && i < 20) begin
         @(posedge clk);
         #1;
         i++;
      end
      if (in_ready) begin
         @(posedge clk);
         #1;
      end else begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: byte 0x%0h not accepted, expected acceptance", b);
      end
      in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gm, input bit push,
                            input logic [AW-1:0] a);
      for (int i = 0; i < 4; i++) begin
         if (push && i == 3) exp_q.push_back({a, w});
         send_byte(w[8*i +: 8], gm);
      end
   endtask

   task automatic probe_ignored(input string tag);
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = 8'($urandom);
         chk(tag, 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx, input bit with_reset);
      logic [AW-1:0] a;
      logic [31:0]   w;
      if (with_reset) do_reset();
      send_word(v.base, v.gap_max, 1'b0, '0);
      if (v.base_only) begin
         chk($sformatf("v%0d_err_latency", idx), 32'(err), 32'(v.exp_err));
         chk($sformatf("v%0d_in_ready_fall", idx), 32'(in_ready), 32'd0);
         chk($sformatf("v%0d_done", idx), 32'(done), 32'd0);
         chk($sformatf("v%0d_core_rst_n", idx), 32'(core_rst_n), 32'd0);
         probe_ignored($sformatf("v%0d_len_ignored", idx));
      end else begin
         send_word(v.len, v.gap_max, 1'b0, '0);
         for (int k = 0; k < int'(v.len); k++) begin
            a = v.base[AW-1:0] + AW'(4 * k);
            w = (k == 0) ? v.w0 : v.w1;
            send_word(w, v.gap_max, 1'b1, a);
         end
         send_byte(v.csum, v.gap_max);
         chk($sformatf("v%0d_done", idx), 32'(done), 32'(v.exp_done));
         chk($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
         chk($sformatf("v%0d_core_rst_n", idx), 32'(core_rst_n), 32'(v.exp_done));
         chk($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd0);
         probe_ignored($sformatf("v%0d_extra_ignored", idx));
         chk($sformatf("v%0d_done_sticky", idx), 32'(done), 32'(v.exp_done));
         chk($sformatf("v%0d_err_sticky", idx), 32'(err), 32'(v.exp_err));
      end
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("v%0d_pending_writes", idx), 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      //        base          len    w0            w1            csum   gap bo done err
      tv[0] = '{32'h00000000, 32'd2, 32'h00000013, 32'h0000006F, 8'h7C, 0, 0, 1, 0};
      tv[1] = '{32'h00000000, 32'd2, 32'h00000013, 32'h0000006F, 8'h00, 0, 0, 0, 1};
      tv[2] = '{32'h00009002, 32'd2, 32'h00000013, 32'h0000006F, 8'h7C, 0, 1, 0, 1};
      tv[3] = '{32'h00000000, 32'd0, 32'h00000000, 32'h00000000, 8'h00, 0, 0, 1, 0};
      tv[4] = '{32'h0000FFFC, 32'd2, 32'hDEADBEEF, 32'h12345678, 8'h2A, 0, 0, 1, 0};
      tv[5] = '{32'h00000000, 32'd2, 32'h00000013, 32'h0000006F, 8'h7C, 5, 0, 1, 0};

      for (int i = 0; i < 6; i++) run_vec(tv[i], i, 1'b1);

      // Reset mid-payload: word 0 lands, word 1 is cut after two bytes.
      do_reset();
      send_word(32'h00000000, 0, 1'b0, '0);
      send_word(32'd2, 0, 1'b0, '0);
      send_word(32'h00000013, 0, 1'b1, 16'h0000);
      send_byte(8'h6F, 0);
      send_byte(8'h00, 0);
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      repeat (3) @(posedge clk);
      #1;
      chk("midreset_pending_writes", 32'(exp_q.size()), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("midreset_in_ready", 32'(in_ready), 32'd1);
      run_vec(tv[0], 6, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
